// File: rtl/elbeth_data_memory_if.sv
// Data-memory request/ready bus between the ELBETH core (master) and its data memory (slave).
interface elbeth_data_memory_if;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
   logic        mem_ready;
   logic        mem_error;

   modport master (output mem_en, mem_we, mem_addr, mem_size, mem_w_data,
                   input  mem_r_data, mem_ready, mem_error);
   modport slave  (input  mem_en, mem_we, mem_addr, mem_size, mem_w_data,
                   output mem_r_data, mem_ready, mem_error);
endinterface

// File: rtl/elbeth_data_memory.sv
// Word-organised data memory with wait states and byte-lane steering for the ELBETH core.
// Define ELBETH_DMEM_ALIGN_CHECK_EN to abort misaligned accesses instead of forcing alignment.
module elbeth_data_memory #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   elbeth_data_memory_if.slave  bus
);
   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t state, next_state;

   logic [3:0]  cnt;
   logic        we_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, w_data_q;
   logic        err_q;
   logic [31:0] r_data_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_w_data;
   logic [31:0] offset;
   logic        in_range, acc_err, commit;
   logic [1:0]  lane;
   logic [AW-1:0] idx;
   logic [3:0]  be;
   logic [31:0] w_lanes, r_word, r_shift, r_ext;

   // With zero wait states the request is consumed on the same edge that enters RESP,
   // so decode from the live bus while idle and from the latched copy afterwards.
   always_comb begin
      if (state == S_IDLE) begin
         req_we     = bus.mem_we;
         req_size   = bus.mem_size;
         req_addr   = bus.mem_addr;
         req_w_data = bus.mem_w_data;
      end else begin
         req_we     = we_q;
         req_size   = size_q;
         req_addr   = addr_q;
         req_w_data = w_data_q;
      end
   end

   always_comb begin
      offset   = req_addr - BASE_ADDR;
      in_range = (offset >> (AW + 2)) == 32'd0;
      lane     = req_addr[1:0];
`ifdef ELBETH_DMEM_ALIGN_CHECK_EN
      acc_err  = (req_size == 2'b11) || !in_range ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
      acc_err  = (req_size == 2'b11) || !in_range;
      if (req_size == 2'b01)      lane[0] = 1'b0;
      else if (req_size == 2'b10) lane    = 2'b00;
`endif
      idx = offset[AW+1:2];
      case (req_size)
         2'b00: begin
            be      = 4'b0001 << lane;
            w_lanes = {4{req_w_data[7:0]}};
         end
         2'b01: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            w_lanes = {2{req_w_data[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            w_lanes = req_w_data;
         end
      endcase
      r_word  = mem[idx];
      r_shift = r_word >> {lane, 3'b000};
      case (req_size)
         2'b00:   r_ext = {24'd0, r_shift[7:0]};
         2'b01:   r_ext = {16'd0, r_shift[15:0]};
         default: r_ext = r_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (bus.mem_en) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   assign commit = (next_state == S_RESP) && (state != S_RESP);

   always_comb begin
      bus.mem_ready  = (state == S_RESP);
      bus.mem_error  = err_q;
      bus.mem_r_data = r_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= 4'd0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 32'd0;
         w_data_q <= 32'd0;
         err_q    <= 1'b0;
         r_data_q <= 32'd0;
      end else begin
         if (state == S_IDLE && bus.mem_en) begin
            we_q     <= bus.mem_we;
            size_q   <= bus.mem_size;
            addr_q   <= bus.mem_addr;
            w_data_q <= bus.mem_w_data;
            cnt      <= CNT_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            err_q    <= acc_err;
            r_data_q <= (acc_err || req_we) ? 32'd0 : r_ext;
         end else if (state == S_RESP) begin
            err_q    <= 1'b0;
            r_data_q <= 32'd0;
         end
      end
   end

   // Array is deliberately not reset; rst gating keeps a held request from writing while in reset.
   always_ff @(posedge clk) begin
      if (commit && rst && req_we && !acc_err)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= w_lanes[8*b +: 8];
   end
endmodule

// File: doc/elbeth_data_memory.md
# elbeth_data_memory

Single-port, word-organised data memory that acts as the responder on the ELBETH core's data-memory request/ready interface. It accepts one load or store request at a time, applies a configurable number of wait states, performs byte-lane steering, and answers with a one-cycle `mem_ready` pulse carrying read data and an error flag. It sits outside the core, between the core's data-memory port and the system bus/testbench, and is the backing store used for core bring-up.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 4..65536.
- `WAIT_CYCLES`, 1: wait states inserted before the response; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_en` in 1: request valid; held with all request fields stable until `mem_ready`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address.
- `mem_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `mem_w_data` in 32: store data, right-justified (bits [7:0] for byte, [15:0] for halfword).
- `mem_r_data` out 32: load data, right-justified, zero-extended; valid only while `mem_ready`=1.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_error` out 1: valid with `mem_ready`; 1 = access aborted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `mem_en`=1 at an edge → latch addr/size/we/w_data; go to RESP if `WAIT_CYCLES`=0, else load 4-bit counter with `WAIT_CYCLES`-1 and go to WAIT.
- WAIT: counter decrements each edge; at count 0 → RESP. Inputs ignored (latched copy used).
- RESP: `mem_ready`=1 for exactly this cycle; next edge → IDLE unconditionally. `mem_en` ignored in RESP, so back-to-back requests cost `WAIT_CYCLES`+2 cycles each.
- Errors (checked on latched request): `mem_size`=11; address outside [`BASE_ADDR`, `BASE_ADDR`+`DEPTH_WORDS`*4); misalignment (see Configuration). On error: no array write, `mem_r_data`=0, `mem_error`=1.
- Word index = (addr − `BASE_ADDR`)[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Store: byte writes lane `addr[1:0]` with w_data[7:0]; halfword writes lanes {addr[1],0}/{addr[1],1} with w_data[15:0]; word writes all lanes. Other lanes untouched.
- Load: selected byte/halfword shifted to bit 0, upper bits zero; word returned unmodified. Sign extension is done by the core.
- Array contents are not initialised or cleared by reset.

## Timing
- Reset values: `mem_ready`=0, `mem_error`=0, `mem_r_data`=0, state IDLE, counter 0.
- Request sampled at edge E0 → `mem_ready` high in the cycle after edge E0+`WAIT_CYCLES`; latency `WAIT_CYCLES`+1 cycles.
- Store commits on the edge that enters RESP; a following load of the same word sees the new data.
- `mem_r_data`/`mem_error` registered on entry to RESP; returned to 0 on the exit edge.
- Reset asserted mid-transaction (WAIT or RESP): outputs clear immediately, state → IDLE, an uncommitted store is dropped; the core must reissue.
- `mem_en` deasserted during WAIT (protocol violation): transaction still completes on latched values.

## Configuration
- `ELBETH_DMEM_ALIGN_CHECK_EN` defined: halfword with addr[0]=1 or word with addr[1:0]≠00 completes with `mem_error`=1, no write.
- Undefined: no misalignment error; the offending low address bits are forced to 0 (halfword clears addr[0], word clears addr[1:0]) and the access proceeds. Range and size checks are always present.

## Test plan
- Reset, `WAIT_CYCLES`=1: store word 0xDEADBEEF @0x10, load @0x10 → `mem_ready` 2 cycles after each request, `mem_r_data`=0xDEADBEEF, `mem_error`=0.
- Byte store 0xA5 @0x13 over 0x11223344, word load @0x10 → 0xA5223344; byte load @0x12 → 0x00000022; halfword load @0x12 → 0x0000A522.
- `WAIT_CYCLES`=0 and 3: `mem_en` held high continuously → `mem_ready` pulses exactly every 2 and 5 cycles respectively, never two consecutive cycles high.
- Load @`BASE_ADDR`+`DEPTH_WORDS`*4 and `mem_size`=11 → `mem_error`=1, `mem_r_data`=0, array unchanged.
- Word store @0x06 over 0x0 → with macro: error, @0x04 still 0; without: no error, @0x04 reads back store data.
- `rst` low during WAIT of a store 0x12345678 @0x20 → outputs 0 at once, state IDLE; subsequent load @0x20 returns the old value.
